// File: rtl/cartoon_pkg.sv
// Shared pixel and grid types for the window_buffer -> edgedetect path.
package cartoon_pkg;

    localparam int PIX_W       = 8;
    localparam int GRID_W      = 3;
    localparam int GRID_CENTRE = 4;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [8:0]       grid_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory. The read is asynchronous, so the value returned
// in an accept cycle is the one stored before that cycle's write lands.
module line_buffer #(
    parameter  int DEPTH = 640,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write on accept; contents are never read before being rewritten in a frame.
    always_ff @(posedge clk) begin
        if (en) mem[addr] <= wdata;
    end

endmodule

// File: rtl/window_buffer.sv
// Streaming 3x3 neighbourhood generator feeding edgedetect's iGrid.
// Only interior pixels (all 8 neighbours present) produce a window.
module window_buffer
    import cartoon_pkg::*;
#(
    parameter  int IMG_W = 640,
    parameter  int IMG_H = 480,
    parameter  int PIX_W = cartoon_pkg::PIX_W,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_pix_valid,
    output logic               o_pix_ready,
    input  logic [PIX_W-1:0]   i_pix,
    output logic               o_grid_valid,
    input  logic               i_grid_ready,
    output logic [9*PIX_W-1:0] o_grid,
    output logic [RW-1:0]      o_row,
    output logic [CW-1:0]      o_col,
    output logic               o_frame_done
);

    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic                       accept;
    logic                       col_last;
    logic                       row_last;
    logic                       interior;
    logic [PIX_W-1:0]           lb0_rd;
    logic [PIX_W-1:0]           lb1_rd;
    logic [8:0][PIX_W-1:0]      win;
    logic [8:0][PIX_W-1:0]      win_nxt;
    logic [8:0][PIX_W-1:0]      grid_q;

    // Single output register: ready depends only on output-register state.
    assign o_pix_ready = !o_grid_valid || i_grid_ready;
    assign accept      = i_pix_valid && o_pix_ready;
    assign col_last    = (col == CW'(IMG_W - 1));
    assign row_last    = (row == RW'(IMG_H - 1));
    assign interior    = (row >= RW'(2)) && (col >= CW'(2));
    assign o_grid      = grid_q;

    // lb0 holds row r-1, lb1 holds row r-2; lb0's old value cascades into lb1.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .wdata (i_pix),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Shift the window left one column and append the new column on the right.
    always_comb begin
        win_nxt = win;
        for (int wr = 0; wr < GRID_W; wr++) begin
            for (int wc = 0; wc < GRID_W - 1; wc++) begin
                win_nxt[GRID_W*wr + wc] = win[GRID_W*wr + wc + 1];
            end
        end
        win_nxt[GRID_W*0 + GRID_W - 1] = lb1_rd;
        win_nxt[GRID_W*1 + GRID_W - 1] = lb0_rd;
        win_nxt[GRID_W*2 + GRID_W - 1] = i_pix;
    end

    // Raster counters, shift window and the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            win          <= '0;
            grid_q       <= '0;
            o_grid_valid <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= accept && col_last && row_last;
            if (accept) begin
                win <= win_nxt;
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) row <= row_last ? '0 : row + RW'(1);
            end
            // A new window may replace a consumed one in the same cycle.
            if (accept && interior) begin
                grid_q       <= win_nxt;
                o_grid_valid <= 1'b1;
                o_row        <= row - RW'(1);
                o_col        <= col - CW'(1);
            end else if (i_grid_ready) begin
                o_grid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer: three frame geometries share one stimulus bus,
// the selected instance is checked against a coordinate-based image model.
module tb_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       i_pix_valid;
    logic       i_grid_ready;
    logic [7:0] i_pix;

    logic a_rdy, a_gv, a_fd; logic [71:0] a_grid; logic [1:0] a_row; logic [1:0] a_col;
    logic b_rdy, b_gv, b_fd; logic [71:0] b_grid; logic [2:0] b_row; logic [2:0] b_col;
    logic c_rdy, c_gv, c_fd; logic [71:0] c_grid; logic [2:0] c_row; logic [2:0] c_col;

    window_buffer #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) dut_a (
        .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .o_pix_ready(a_rdy), .i_pix(i_pix),
        .o_grid_valid(a_gv), .i_grid_ready(i_grid_ready), .o_grid(a_grid),
        .o_row(a_row), .o_col(a_col), .o_frame_done(a_fd));

    window_buffer #(.IMG_W(5), .IMG_H(5), .PIX_W(8)) dut_b (
        .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .o_pix_ready(b_rdy), .i_pix(i_pix),
        .o_grid_valid(b_gv), .i_grid_ready(i_grid_ready), .o_grid(b_grid),
        .o_row(b_row), .o_col(b_col), .o_frame_done(b_fd));

    window_buffer #(.IMG_W(8), .IMG_H(6), .PIX_W(8)) dut_c (
        .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .o_pix_ready(c_rdy), .i_pix(i_pix),
        .o_grid_valid(c_gv), .i_grid_ready(i_grid_ready), .o_grid(c_grid),
        .o_row(c_row), .o_col(c_col), .o_frame_done(c_fd));

    int          sel;
    logic        rdy, gv, fd;
    logic [71:0] grid;
    int          row, col;

    always_comb begin
        rdy = a_rdy; gv = a_gv; fd = a_fd; grid = a_grid; row = int'(a_row); col = int'(a_col);
        if (sel == 1) begin
            rdy = b_rdy; gv = b_gv; fd = b_fd; grid = b_grid; row = int'(b_row); col = int'(b_col);
        end else if (sel == 2) begin
            rdy = c_rdy; gv = c_gv; fd = c_fd; grid = c_grid; row = int'(c_row); col = int'(c_col);
        end
    end

    typedef struct {
        logic [71:0] grid;
        int          row;
        int          col;
    } win_t;

    win_t        exp_q[$];
    win_t        got_q[$];
    logic [7:0]  src[$];
    logic [7:0]  img [0:7][0:7];
    int          checks = 0;
    int          errors = 0;
    int          cur_w, cur_h, m_row, m_col;
    int          vld_mode, rdy_mode, hold_cnt, fd_count, win_count;
    bit          hold_done;
    logic        gv_exp, fd_exp, hold_prev;
    logic [71:0] held_grid;

    task automatic do_reset();
        rst = 1'b1; i_pix_valid = 1'b0; i_grid_ready = 1'b0; i_pix = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gv !== 1'b0 || fd !== 1'b0 || grid !== 72'h0 || row != 0 || col != 0)
            begin errors++; $display("FAIL reset_outputs: gv=%b fd=%b grid=%h row=%0d col=%0d, required all 0", gv, fd, grid, row, col); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", rdy); end
        gv_exp = 1'b0; fd_exp = 1'b0; hold_prev = 1'b0; m_row = 0; m_col = 0;
        exp_q.delete();
    endtask

    task automatic start(input int s, input int w, input int h, input int vm, input int rm);
        sel = s; cur_w = w; cur_h = h; vld_mode = vm; rdy_mode = rm;
        hold_cnt = 0; hold_done = 0; fd_count = 0; win_count = 0;
        got_q.delete(); src.delete();
        do_reset();
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        logic acc, pushed, fd_next, rdy_m;
        logic [7:0]  v;
        logic [71:0] g;
        win_t        e;
        @(posedge clk); #1;
        i_pix_valid = (src.size() > 0) && (vld_mode == 0 || $urandom_range(0, 1) == 1);
        i_pix = (src.size() > 0) ? src[0] : 8'h00;
        if (rdy_mode == 1) i_grid_ready = ($urandom_range(0, 1) == 1);
        else if (rdy_mode == 2 && !hold_done && gv_exp) begin
            if (hold_cnt < 5) begin i_grid_ready = 1'b0; hold_cnt++; end
            else begin i_grid_ready = 1'b1; hold_done = 1; end
        end else i_grid_ready = 1'b1;
        @(negedge clk);
        rdy_m = !gv_exp || i_grid_ready;
        checks++;
        if (gv !== gv_exp) begin errors++; $display("FAIL grid_valid: got %b required %b", gv, gv_exp); end
        checks++;
        if (fd !== fd_exp) begin errors++; $display("FAIL frame_done: got %b required %b", fd, fd_exp); end
        if (fd === 1'b1) fd_count++;
        checks++;
        if (rdy !== rdy_m) begin errors++; $display("FAIL pix_ready: got %b required %b", rdy, rdy_m); end
        if (hold_prev && gv_exp) begin
            checks++;
            if (grid !== held_grid) begin errors++; $display("FAIL hold_stable: got %h required %h", grid, held_grid); end
        end
        if (gv_exp && i_grid_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL extra_window: got %h required none", grid); end
            else begin
                e = exp_q.pop_front();
                if (grid !== e.grid || row != e.row || col != e.col) begin
                    errors++;
                    $display("FAIL window: got %h r%0d c%0d required %h r%0d c%0d", grid, row, col, e.grid, e.row, e.col);
                end
            end
            got_q.push_back('{grid, row, col});
            win_count++;
        end
        acc = i_pix_valid && rdy_m;
        pushed = 1'b0; fd_next = 1'b0;
        if (acc) begin
            v = src.pop_front();
            img[m_row][m_col] = v;
            if (m_row >= 2 && m_col >= 2) begin
                for (int k = 0; k < 9; k++) g[k*8 +: 8] = img[m_row-2+k/3][m_col-2+k%3];
                exp_q.push_back('{g, m_row-1, m_col-1});
                pushed = 1'b1;
            end
            fd_next = (m_row == cur_h-1) && (m_col == cur_w-1);
            if (m_col == cur_w-1) begin
                m_col = 0;
                m_row = (m_row == cur_h-1) ? 0 : m_row + 1;
            end else m_col++;
        end
        hold_prev = gv_exp && !i_grid_ready;
        held_grid = grid;
        gv_exp = pushed ? 1'b1 : (gv_exp && !i_grid_ready);
        fd_exp = fd_next;
    endtask

    task automatic run(input int max_cycles);
        int n = 0;
        while ((src.size() > 0 || gv_exp) && n < max_cycles) begin step(); n++; end
        if (n >= max_cycles) begin
            checks++; errors++;
            $display("FAIL timeout: %0d pixels left after %0d cycles, required 0", src.size(), n);
        end
        step(); step();
    endtask

    task automatic push_seq(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) src.push_back(8'(first + i));
    endtask

    task automatic check_frame1(input string tag);
        logic [71:0] c1, c2;
        c1 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        c2 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
        checks++;
        if (win_count != 2) begin errors++; $display("FAIL %s_count: got %0d required 2", tag, win_count); end
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL %s_frame_done_count: got %0d required 1", tag, fd_count); end
        checks++;
        if (got_q.size() < 2) begin errors++; $display("FAIL %s_first: got %0d windows required 2", tag, got_q.size()); end
        else begin
            if (got_q[0].grid !== c1 || got_q[0].row != 1 || got_q[0].col != 1) begin
                errors++; $display("FAIL %s_first: got %h r%0d c%0d required %h r1 c1", tag, got_q[0].grid, got_q[0].row, got_q[0].col, c1);
            end
            checks++;
            if (got_q[1].grid !== c2 || got_q[1].row != 1 || got_q[1].col != 2) begin
                errors++; $display("FAIL %s_second: got %h r%0d c%0d required %h r1 c2", tag, got_q[1].grid, got_q[1].row, got_q[1].col, c2);
            end
        end
    endtask

    task automatic test_reset();
        start(0, 4, 3, 0, 0);
    endtask

    task automatic test_ordering();
        start(0, 4, 3, 0, 0);
        push_seq(0, 12);
        run(200);
        check_frame1("ordering");
    endtask

    task automatic test_latency();
        int centres[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        start(1, 5, 5, 0, 0);
        push_seq(0, 25);
        run(300);
        checks++;
        if (win_count != 9) begin errors++; $display("FAIL latency_count: got %0d required 9", win_count); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].grid[39:32] !== 8'(centres[i])) begin
                errors++; $display("FAIL latency_centre%0d: got %0d required %0d", i, got_q[i].grid[39:32], centres[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        start(0, 4, 3, 0, 2);
        push_seq(0, 12);
        run(200);
        check_frame1("backpressure");
        checks++;
        if (hold_cnt != 5) begin errors++; $display("FAIL backpressure_hold: got %0d required 5", hold_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] c3;
        c3 = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
        start(0, 4, 3, 0, 0);
        push_seq(0, 12);
        push_seq(100, 12);
        run(300);
        checks++;
        if (win_count != 4 || fd_count != 2) begin
            errors++; $display("FAIL b2b_counts: got %0d windows %0d done, required 4 and 2", win_count, fd_count);
        end
        checks++;
        if (got_q.size() < 3) begin errors++; $display("FAIL b2b_frame2: got %0d windows required 4", got_q.size()); end
        else if (got_q[2].grid !== c3) begin
            errors++; $display("FAIL b2b_frame2: got %h required %h", got_q[2].grid, c3);
        end
    endtask

    task automatic test_reset_mid();
        start(0, 4, 3, 0, 0);
        push_seq(0, 7);
        run(100);
        do_reset();
        got_q.delete(); fd_count = 0; win_count = 0;
        push_seq(0, 12);
        run(200);
        check_frame1("reset_mid");
    endtask

    task automatic test_random();
        start(2, 8, 6, 1, 1);
        for (int i = 0; i < 48; i++) src.push_back(8'($urandom_range(0, 255)));
        run(2000);
        checks++;
        if (win_count != 24 || exp_q.size() != 0) begin
            errors++; $display("FAIL random_count: got %0d windows %0d pending, required 24 and 0", win_count, exp_q.size());
        end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_ordering();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
